// File: rtl/tx_byte_fifo_if.sv
// Handshake bundle between the byte producer, the FIFO and the serializer.
// Optional tx_parity signal exists only when TX_PARITY_EN is defined.
interface tx_byte_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_ovf;
`ifdef TX_PARITY_EN
  logic          tx_parity;
`endif

  modport master (
    output wr_en, wr_data, tx_ready, clr_ovf,
`ifdef TX_PARITY_EN
    input  tx_parity,
`endif
    input  full, tx_data, tx_valid, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_ready, clr_ovf,
`ifdef TX_PARITY_EN
    output tx_parity,
`endif
    output full, tx_data, tx_valid, count, overflow
  );
endinterface

// File: rtl/tx_byte_fifo.sv
// FWFT byte FIFO feeding the serial transmitter, with sticky overflow.
// Define TX_PARITY_EN to add the even-parity output of the head byte.
module tx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  tx_byte_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push;
  logic          drop;

  // Status comes only from the registered count, never from the strobes.
  assign full  = (cnt == FULL_CNT);
  assign valid = (cnt != '0);

  assign pop  = valid & bus.tx_ready;
  assign push = bus.wr_en & (~full | pop);
  assign drop = bus.wr_en & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)
        cnt <= cnt + (AW+1)'(1);
      else if (pop & ~push)
        cnt <= cnt - (AW+1)'(1);
      // A fresh drop beats a same-cycle clear.
      if (drop)
        ovf <= 1'b1;
      else if (bus.clr_ovf)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.tx_data  = mem[rd_ptr];
  assign bus.tx_valid = valid;
  assign bus.full     = full;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;

`ifdef TX_PARITY_EN
  assign bus.tx_parity = ^mem[rd_ptr];
`endif

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Directed vector bench for tx_byte_fifo (DEPTH=16).
// Parity checks run only when TX_PARITY_EN is defined.
module tb_tx_byte_fifo;
  logic clk = 1'b0;
  logic rst;

  tx_byte_fifo_if bus ();

  tx_byte_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [7:0]  d;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [7:0]  ed;
    logic [4:0]  ec;
    logic        ef;
    logic        eo;
    string       nm;
  } vec_t;

  vec_t tv [80];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic w, input logic [7:0] d,
                     input logic rdy, input logic clr, input logic ev,
                     input logic [7:0] ed, input int ec, input logic ef,
                     input logic eo, input string nm);
    tv[nv].rst = r;
    tv[nv].wr  = w;
    tv[nv].d   = d;
    tv[nv].rdy = rdy;
    tv[nv].clr = clr;
    tv[nv].ev  = ev;
    tv[nv].ed  = ed;
    tv[nv].ec  = 5'(ec);
    tv[nv].ef  = ef;
    tv[nv].eo  = eo;
    tv[nv].nm  = nm;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] d,
                       input logic rdy, input logic clr);
    rst         = r;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.tx_ready = rdy;
    bus.clr_ovf = clr;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // rst wr d rdy clr | ev ed cnt full ovf
    add(1,0,8'h00,0,0, 0,8'h00,0,0,0, "reset");
    add(0,1,8'hA5,0,0, 1,8'hA5,1,0,0, "write_a5");
    for (int i = 0; i < 5; i++)
      add(0,0,8'h00,0,0, 1,8'hA5,1,0,0, "hold_a5");
    add(0,0,8'h00,1,0, 0,8'h00,0,0,0, "drain_a5");
    for (int k = 1; k <= 16; k++)
      add(0,1,8'(k),0,0, 1,8'h01,k,(k == 16),0, "fill");
    add(0,1,8'h55,0,0, 1,8'h01,16,1,1, "drop_55");
    add(0,0,8'h00,0,1, 1,8'h01,16,1,0, "clr_ovf");
    add(0,1,8'h66,0,1, 1,8'h01,16,1,1, "drop_beats_clr");
    add(0,0,8'h00,0,1, 1,8'h01,16,1,0, "clr_ovf2");
    add(0,1,8'h77,1,0, 1,8'h02,16,1,0, "full_push_pop");
    for (int j = 1; j <= 16; j++)
      add(0,0,8'h00,1,0, (j < 16),
          (j < 15) ? 8'(8'h02 + j) : 8'h77, 16 - j, 0, 0, "drain_order");
    add(0,0,8'h00,1,0, 0,8'h00,0,0,0, "ready_empty");
    add(0,1,8'h99,1,0, 1,8'h99,1,0,0, "write_empty_rdy");
    add(0,0,8'h00,1,0, 0,8'h00,0,0,0, "pop_99");

    for (int i = 0; i < nv; i++) begin
      drive(tv[i].rst, tv[i].wr, tv[i].d, tv[i].rdy, tv[i].clr);
      step();
      chk({tv[i].nm, "_valid"}, 32'(bus.tx_valid), 32'(tv[i].ev));
      if (tv[i].ev)
        chk({tv[i].nm, "_data"}, 32'(bus.tx_data), 32'(tv[i].ed));
      chk({tv[i].nm, "_count"}, 32'(bus.count), 32'(tv[i].ec));
      chk({tv[i].nm, "_full"}, 32'(bus.full), 32'(tv[i].ef));
      chk({tv[i].nm, "_ovf"}, 32'(bus.overflow), 32'(tv[i].eo));
    end

    // Streaming write+read across two pointer wraps.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
      step();
      chk("stream_valid", 32'(bus.tx_valid), 32'd1);
      chk("stream_data", 32'(bus.tx_data), 32'(i));
      chk("stream_count", 32'(bus.count), 32'd1);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("stream_end_count", 32'(bus.count), 32'd0);

    // Reset in the middle of operation discards everything.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
      step();
    end
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_full", 32'(bus.full), 32'd0);
    drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step();
    chk("post_rst_valid", 32'(bus.tx_valid), 32'd1);
    chk("post_rst_data", 32'(bus.tx_data), 32'h3C);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("post_rst_drain", 32'(bus.count), 32'd0);

`ifdef TX_PARITY_EN
    begin
      logic [7:0] pb [4];
      logic       pe [4];
      pb[0] = 8'h00; pe[0] = 1'b0;
      pb[1] = 8'h01; pe[1] = 1'b1;
      pb[2] = 8'hFF; pe[2] = 1'b0;
      pb[3] = 8'h80; pe[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b1, pb[i], 1'b0, 1'b0);
        step();
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("parity_head", 32'(bus.tx_data), 32'(pb[i]));
        chk("parity", 32'(bus.tx_parity), 32'(pe[i]));
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
      end
      chk("parity_drained", 32'(bus.count), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_byte_fifo.md
Name: tx_byte_fifo

Overview:
- Byte buffer that sits directly upstream of the serial transmitter.
- Accepts bytes from a parallel producer, stores up to DEPTH of them, and presents them one at a time to the serializer.
- Uses first-word-fall-through (FWFT) with a valid/ready handshake; the serializer pulls the next byte when it begins a new frame.
- Reports fill level, full status and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  producer write strobe, one byte per cycle.
- wr_data  input  8  byte to enqueue.
- full  output  1  high when count == DEPTH.
- tx_data  output  8  head-of-queue byte; valid only while tx_valid is high.
- tx_valid  output  1  high when count != 0.
- tx_ready  input  1  serializer takes the head byte this cycle.
- count  output  AW+1  number of stored bytes, 0..DEPTH.
- overflow  output  1  sticky; a write was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst high at an edge):
  - rd_ptr, wr_ptr and count go to 0; full=0, tx_valid=0, overflow=0.
  - Storage contents are not cleared; tx_data is don't-care while tx_valid=0.
  - Reset mid-operation discards all queued bytes; the first cycle after rst drops shows an empty FIFO.
- Definitions per cycle:
  - pop = tx_valid & tx_ready.
  - push = wr_en & (!full | pop).
- Push: mem[wr_ptr] <= wr_data, and wr_ptr increments modulo DEPTH (natural wrap of AW bits).
- Pop: rd_ptr increments modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- FWFT latency:
  - A byte written at edge N appears on tx_data with tx_valid=1 in the cycle after edge N.
  - tx_data = mem[rd_ptr], read combinationally from storage.
- tx_data holds stable while tx_valid=1 and tx_ready=0; the serializer may sample it at any later cycle.
- Boundary conditions:
  - Empty with wr_en: the byte is accepted; no pop is possible that cycle because tx_valid=0.
  - tx_ready while empty: ignored; rd_ptr and count unchanged.
  - Full with wr_en and pop in the same cycle: the write is accepted, count stays at DEPTH, full stays 1.
  - Full with wr_en and no pop: the byte is dropped, pointers unchanged, overflow <= 1.
  - overflow stays set until rst or clr_ovf.
  - clr_ovf and a new drop in the same cycle: the set wins (overflow stays 1).
  - Pointer wrap: after DEPTH pushes and DEPTH pops, rd_ptr == wr_ptr == 0 and ordering is preserved across the wrap.
- full and tx_valid are decoded from the registered count, so they carry no combinational path from wr_en or tx_ready.
- No internal state machine beyond pointer/count registers; ordering is strictly FIFO.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined:
  - Adds output tx_parity (1 bit), the even parity of tx_data: XOR of all 8 bits.
  - Computed combinationally from the head entry and valid whenever tx_valid=1.
  - The serializer uses it as a ninth bit before stop.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then write 0xA5 in one cycle with tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5, count=1; tx_data holds 0xA5 for 5 idle cycles.
- Write 0x01..0x10 (DEPTH=16) with no reads -> full=1, count=16, overflow=0. Write 0x55 with tx_ready=0 -> dropped, overflow=1, count=16. Pulse clr_ovf -> overflow=0.
- Full FIFO, then wr_en=1 with 0x77 and tx_ready=1 in the same cycle -> 0x01 popped, 0x77 accepted, count=16. Drain all -> bytes 0x02..0x10 then 0x77 in order.
- Continuous write plus read of 40 incrementing bytes, tx_ready=1 always -> output sequence 0x00..0x27 with no gaps after the first-cycle latency and no loss across two pointer wraps; count never exceeds 1.
- Load 5 bytes, assert rst for one cycle while tx_ready=1 -> next cycle count=0, tx_valid=0, full=0. New write 0x3C appears as the first output.
- With TX_PARITY_EN defined, head bytes 0x00, 0x01, 0xFF, 0x80 -> tx_parity = 0, 1, 0, 1 respectively.
